// File: rtl/hsv_color_tracker_if.sv
// Pixel stream, runtime thresholds and per-frame results of the HSV colour tracker.
// The tracker is the slave; the upstream converter/ECU side is the master.
interface hsv_color_tracker_if #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W * IMG_H + 1);

    logic          frame_start;
    logic          pix_valid;
    logic [9:0]    h_in;
    logic [6:0]    s_in;
    logic [6:0]    v_in;
    logic [9:0]    h_min;
    logic [9:0]    h_max;
    logic [6:0]    s_min;
    logic [6:0]    v_min;
    logic          mask_valid;
    logic          mask_out;
    logic          result_valid;
    logic          obj_found;
    logic [XW-1:0] x_min;
    logic [XW-1:0] x_max;
    logic [YW-1:0] y_min;
    logic [YW-1:0] y_max;
    logic [CW-1:0] pix_count;
    logic          frame_abort;

    modport master (
        output frame_start, pix_valid, h_in, s_in, v_in, h_min, h_max, s_min, v_min,
        input  mask_valid, mask_out, result_valid, obj_found,
               x_min, x_max, y_min, y_max, pix_count, frame_abort
    );

    modport slave (
        input  frame_start, pix_valid, h_in, s_in, v_in, h_min, h_max, s_min, v_min,
        output mask_valid, mask_out, result_valid, obj_found,
               x_min, x_max, y_min, y_max, pix_count, frame_abort
    );
endinterface

// File: rtl/hsv_color_tracker.sv
// Per-pixel HSV threshold mask plus per-frame bounding box / pixel count of matches.
// Frame results are latched in a one-cycle REPORT state after the last pixel.
module hsv_color_tracker #(
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int MIN_PIXELS = 64
) (
    input  logic               clk,
    input  logic               reset,
    hsv_color_tracker_if.slave bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W * IMG_H + 1);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_ZERO = {XW{1'b0}};
    localparam logic [YW-1:0] Y_ZERO = {YW{1'b0}};
    localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_MIN  = CW'(MIN_PIXELS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t        state_r, state_nx_s;
    logic [XW-1:0] x_r, x_nx_s, cur_x_s;
    logic [YW-1:0] y_r, y_nx_s, cur_y_s;
    logic [XW-1:0] xmin_r, xmax_r, xmin_b_s, xmax_b_s, xmin_nx_s, xmax_nx_s;
    logic [YW-1:0] ymin_r, ymax_r, ymin_b_s, ymax_b_s, ymin_nx_s, ymax_nx_s;
    logic [CW-1:0] cnt_r, cnt_b_s, cnt_nx_s;
    logic          hue_ok_s, match_s, accept_s, last_pix_s;

    // frame_start makes a same-cycle pixel pixel (0,0) of the new frame, whatever the state
    assign accept_s = bus.pix_valid && (bus.frame_start || (state_r == ACTIVE));

    // Threshold compare; h_min > h_max denotes a window wrapping through 0 degrees
    always_comb begin
        hue_ok_s = 1'b0;
        if (bus.h_min <= bus.h_max) begin
            hue_ok_s = (bus.h_in >= bus.h_min) && (bus.h_in <= bus.h_max);
        end else begin
            hue_ok_s = (bus.h_in >= bus.h_min) || (bus.h_in <= bus.h_max);
        end
        match_s = hue_ok_s && (bus.s_in >= bus.s_min) && (bus.v_in >= bus.v_min);
    end

    // Coordinate and accumulator next-state, starting from init values on frame_start
    always_comb begin
        if (bus.frame_start) begin
            cur_x_s  = X_ZERO;
            cur_y_s  = Y_ZERO;
            xmin_b_s = X_LAST;
            xmax_b_s = X_ZERO;
            ymin_b_s = Y_LAST;
            ymax_b_s = Y_ZERO;
            cnt_b_s  = C_ZERO;
        end else begin
            cur_x_s  = x_r;
            cur_y_s  = y_r;
            xmin_b_s = xmin_r;
            xmax_b_s = xmax_r;
            ymin_b_s = ymin_r;
            ymax_b_s = ymax_r;
            cnt_b_s  = cnt_r;
        end
        x_nx_s     = cur_x_s;
        y_nx_s     = cur_y_s;
        xmin_nx_s  = xmin_b_s;
        xmax_nx_s  = xmax_b_s;
        ymin_nx_s  = ymin_b_s;
        ymax_nx_s  = ymax_b_s;
        cnt_nx_s   = cnt_b_s;
        last_pix_s = (cur_x_s == X_LAST) && (cur_y_s == Y_LAST);
        if (accept_s) begin
            if (cur_x_s == X_LAST) begin
                x_nx_s = X_ZERO;
                y_nx_s = (cur_y_s == Y_LAST) ? Y_ZERO : (cur_y_s + Y_ONE);
            end else begin
                x_nx_s = cur_x_s + X_ONE;
            end
            if (match_s) begin
                xmin_nx_s = (cur_x_s < xmin_b_s) ? cur_x_s : xmin_b_s;
                xmax_nx_s = (cur_x_s > xmax_b_s) ? cur_x_s : xmax_b_s;
                ymin_nx_s = (cur_y_s < ymin_b_s) ? cur_y_s : ymin_b_s;
                ymax_nx_s = (cur_y_s > ymax_b_s) ? cur_y_s : ymax_b_s;
                cnt_nx_s  = cnt_b_s + C_ONE;
            end else begin
                cnt_nx_s  = cnt_b_s;
            end
        end else begin
            x_nx_s = cur_x_s;
        end
    end

    // Frame FSM next-state
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.frame_start) state_nx_s = ACTIVE;
                else                 state_nx_s = IDLE;
            end
            ACTIVE: begin
                if (bus.frame_start)                 state_nx_s = ACTIVE;
                else if (accept_s && last_pix_s)     state_nx_s = REPORT;
                else                                 state_nx_s = ACTIVE;
            end
            REPORT: begin
                if (bus.frame_start) state_nx_s = ACTIVE;
                else                 state_nx_s = IDLE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State, coordinate and accumulator registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            x_r     <= X_ZERO;
            y_r     <= Y_ZERO;
            xmin_r  <= X_LAST;
            xmax_r  <= X_ZERO;
            ymin_r  <= Y_LAST;
            ymax_r  <= Y_ZERO;
            cnt_r   <= C_ZERO;
        end else begin
            state_r <= state_nx_s;
            x_r     <= x_nx_s;
            y_r     <= y_nx_s;
            xmin_r  <= xmin_nx_s;
            xmax_r  <= xmax_nx_s;
            ymin_r  <= ymin_nx_s;
            ymax_r  <= ymax_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Registered mask, abort and frame-result outputs; results hold between reports
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mask_valid   <= 1'b0;
            bus.mask_out     <= 1'b0;
            bus.frame_abort  <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.obj_found    <= 1'b0;
            bus.x_min        <= X_ZERO;
            bus.x_max        <= X_ZERO;
            bus.y_min        <= Y_ZERO;
            bus.y_max        <= Y_ZERO;
            bus.pix_count    <= C_ZERO;
        end else begin
            bus.mask_valid   <= accept_s;
            bus.mask_out     <= accept_s && match_s;
            bus.frame_abort  <= bus.frame_start && (state_r == ACTIVE);
            bus.result_valid <= (state_r == REPORT);
            if (state_r == REPORT) begin
                if (cnt_r == C_ZERO) begin
                    bus.obj_found <= 1'b0;
                    bus.x_min     <= X_ZERO;
                    bus.x_max     <= X_ZERO;
                    bus.y_min     <= Y_ZERO;
                    bus.y_max     <= Y_ZERO;
                    bus.pix_count <= C_ZERO;
                end else begin
                    bus.obj_found <= (cnt_r >= C_MIN);
                    bus.x_min     <= xmin_r;
                    bus.x_max     <= xmax_r;
                    bus.y_min     <= ymin_r;
                    bus.y_max     <= ymax_r;
                    bus.pix_count <= cnt_r;
                end
            end else begin
                bus.obj_found <= bus.obj_found;
            end
        end
    end
endmodule
